// File: rtl/hc595_shift_driver.sv
// Serial driver for a chain of cascaded 74HC595 shift registers.
// Shifts a WIDTH-bit frame out on ser/srclk, then pulses rclk to latch it.
// srclk and rclk run at a half-period of CLK_DIV system clock cycles.
// Optional macro HC595_LSB_FIRST_EN: shift data_in[0] first instead of data_in[WIDTH-1].
module hc595_shift_driver #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CLK_DIV = 50
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             ser,
  output logic             srclk,
  output logic             rclk,
  output logic             oe_n,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam logic [15:0]   DivLast   = 16'(CLK_DIV - 1);
  localparam logic [BW-1:0] BitsTotal = BW'(WIDTH);

  typedef enum logic [2:0] {StIdle, StShiftLo, StShiftHi, StLatch, StDone} state_e;

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [BW-1:0]    bit_next;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             ser_q, ser_d;
  logic             srclk_q, rclk_q, busy_q, done_q;
  logic             oe_n_q, oe_n_d;
  logic             phase_end;

`ifdef HC595_LSB_FIRST_EN
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return v[0];
  endfunction
  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] v);
    return v >> 1;
  endfunction
`else
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return v[WIDTH-1];
  endfunction
  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] v);
    return v << 1;
  endfunction
`endif

  assign phase_end = (cnt_q == DivLast);
  assign bit_next  = bit_q + 1'b1;

  // Next-state, counter and shift-register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    sr_d    = sr_q;
    ser_d   = ser_q;
    oe_n_d  = oe_n_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) begin
          // First bit goes straight to ser; sr keeps the remaining bits.
          state_d = StShiftLo;
          ser_d   = head_bit(data_in);
          sr_d    = drop_head(data_in);
          bit_d   = '0;
        end
      end
      StShiftLo: begin
        if (phase_end) state_d = StShiftHi;
      end
      StShiftHi: begin
        if (phase_end) begin
          if (bit_next == BitsTotal) begin
            state_d = StLatch;
            bit_d   = '0;
          end else begin
            // ser only moves here, on the srclk falling edge.
            state_d = StShiftLo;
            bit_d   = bit_next;
            ser_d   = head_bit(sr_q);
            sr_d    = drop_head(sr_q);
          end
        end
      end
      StLatch: begin
        if (phase_end) begin
          state_d = StDone;
          oe_n_d  = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // State, counters and registered outputs; outputs decoded from the next state.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      ser_q   <= 1'b0;
      srclk_q <= 1'b0;
      rclk_q  <= 1'b0;
      oe_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      ser_q   <= ser_d;
      srclk_q <= (state_d == StShiftHi);
      rclk_q  <= (state_d == StLatch);
      oe_n_q  <= oe_n_d;
      busy_q  <= (state_d == StShiftLo) || (state_d == StShiftHi) || (state_d == StLatch);
      done_q  <= (state_d == StDone);
    end
  end

  assign ser   = ser_q;
  assign srclk = srclk_q;
  assign rclk  = rclk_q;
  assign oe_n  = oe_n_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: doc/hc595_shift_driver.md
HC595_SHIFT_DRIVER -- requirements
Module: hc595_shift_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of bits per frame (cascaded 74HC595 chips x 8); legal range 1..32.
REQ-002 SHALL have parameter CLK_DIV, default 50: half-period of srclk and rclk, in clk_100MHz cycles; legal range 1..65535.
REQ-003 SHALL have port clk_100MHz  input  1  system clock; the only clock, all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  frame request, e.g. 1 Hz-domain update strobe re-timed to clk_100MHz.
REQ-006 SHALL have port data_in  input  WIDTH  frame to shift out.
REQ-007 SHALL have port ser  output  1  serial data to 74HC595 DS.
REQ-008 SHALL have port srclk  output  1  shift clock to SHCP.
REQ-009 SHALL have port rclk  output  1  latch clock to STCP.
REQ-010 SHALL have port oe_n  output  1  output enable to OE#, active-low.
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port done  output  1  one-cycle frame-complete pulse.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE; all outputs registered.
REQ-014 In IDLE with start=1 SHALL capture data_in into an internal shift register, set busy=1 next cycle, go to SHIFT_LO.
REQ-015 start while not in IDLE (including DONE) SHALL be ignored; data_in not sampled.
REQ-016 SHIFT_LO: srclk=0, ser=current bit, held CLK_DIV cycles, then go to SHIFT_HI.
REQ-017 SHIFT_HI: srclk=1 for CLK_DIV cycles, ser stable; on exit, advance bit counter; if WIDTH bits sent go to LATCH, else SHIFT_LO.
REQ-018 ser SHALL change only in SHIFT_LO, never coincident with a srclk rising edge.
REQ-019 LATCH: srclk=0, rclk=1 for CLK_DIV cycles, then rclk=0 and go to DONE.
REQ-020 DONE: done=1, busy=0 for exactly one cycle, then IDLE.
REQ-021 busy SHALL be high for exactly 2*CLK_DIV*WIDTH + CLK_DIV consecutive cycles per frame.
REQ-022 oe_n SHALL stay 1 from reset until the first LATCH completes, then 0 permanently until the next reset.
REQ-023 Half-period counter SHALL be 16 bits, bit counter ceil(log2(WIDTH+1)) bits; both cleared on each state change; no wrap within a phase.
REQ-024 In IDLE: srclk=0, rclk=0, ser holds last driven value.

Reset
REQ-025 rst_n=0 SHALL asynchronously force ser=0, srclk=0, rclk=0, oe_n=1, busy=0, done=0, state IDLE, counters 0, shift register 0.
REQ-026 Reset mid-frame SHALL abort without an rclk pulse; the 74HC595 output latches keep the previous frame.
REQ-027 Deassertion SHALL be followed by IDLE; start in the first cycle after deassertion SHALL be accepted.

Configuration
REQ-028 Macro HC595_LSB_FIRST_EN: when defined, bit order is data_in[0] first, data_in[WIDTH-1] last.
REQ-029 Without HC595_LSB_FIRST_EN, bit order is data_in[WIDTH-1] first (MSB-first), data_in[0] last; timing is identical in both builds.

Verification (WIDTH=8, CLK_DIV=2 unless stated)
REQ-030 start pulse, data_in=8'hA5, default build -> ser sampled at the 8 srclk rises = 1,0,1,0,0,1,0,1; one rclk pulse 2 cycles wide; busy high 34 cycles; done one cycle; oe_n falls after rclk.
REQ-031 Same stimulus with HC595_LSB_FIRST_EN defined -> ser at srclk rises = 1,0,1,0,0,1,0,1 (A5 is bit-palindromic), then data_in=8'h01 -> 1,0,0,0,0,0,0,0 (default build: 0,0,0,0,0,0,0,1).
REQ-032 start held high continuously, data_in changed to 8'h3C mid-frame -> first frame shifts 8'hA5 unchanged; second frame (8'h3C) starts the cycle after done.
REQ-033 rst_n pulled low during the 4th SHIFT_HI -> all outputs at reset values immediately; no rclk pulse; oe_n stays 1.
REQ-034 WIDTH=16, CLK_DIV=50, data_in=16'h8001 -> busy high 1650 cycles; ser high only at the 1st and 16th srclk rises; srclk period 100 cycles (1 MHz).
